register_file_sb: RTL and testbench
===================================

# register_file_sb

Parametrised integer register file with a built-in scoreboard, the successor to the single-cycle core's fixed 32×32 register file for the pipelined core. It provides two combinational read ports and one clocked write-back port, with optional write-to-read bypass. A busy bit per register is set at issue and cleared at write-back, so the hazard unit can stall on RAW dependences. Register 0 is hardwired to zero and is never busy.

## Interface

Parameters:
- XLEN, 32, data width in bits.
- ADDR_W, 5, address width; depth = 2^ADDR_W registers.
- BYPASS, 1, when 1 a same-cycle write-back is forwarded to the read ports; when 0 it is not.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous and active-high.
- A1  in  ADDR_W  read port 1 address.
- A2  in  ADDR_W  read port 2 address.
- RD1  out  XLEN  read port 1 data (combinational).
- RD2  out  XLEN  read port 2 data (combinational).
- RDY1  out  1  RD1 holds a committed or bypassed value; the register has no pending producer.
- RDY2  out  1  same as RDY1, for port 2.
- WE3  in  1  write-back enable.
- A3  in  ADDR_W  write-back address.
- WD3  in  XLEN  write-back data.
- IE  in  1  issue enable; marks AI as having an in-flight producer.
- AI  in  ADDR_W  issue destination address.
- BUSY  out  2^ADDR_W  scoreboard vector; bit n = register n busy.

## Operation

- Storage: regs[1 .. 2^ADDR_W−1], each XLEN wide. regs[0] is not stored. Reads of address 0 return 0, and RDY for address 0 is 1.
- Write: on a rising edge with rst=0, WE3=1 and A3≠0, regs[A3] ← WD3. A write to A3=0 is discarded.
- Issue: on a rising edge with rst=0, IE=1 and AI≠0, busy[AI] ← 1. An issue to AI=0 is ignored.
- Retire: on a rising edge with rst=0, WE3=1 and A3≠0, busy[A3] ← 0. The retire is ignored if the same edge also issues to AI=A3 (see priority rule below).
- A write-back to a non-busy register is legal. It updates data, and busy stays 0.
- Same-address priority: IE=1, WE3=1, AI=A3≠0 on one edge → data is written and busy[A3] ends at 1, because the issue represents a newer producer.
- Read path for port p (address Ap):
  - If Ap=0 → RDp=0, RDYp=1.
  - Else if BYPASS=1, WE3=1 and A3=Ap → RDp=WD3, RDYp=1.
  - Else → RDp=regs[Ap], RDYp=!busy[Ap].
- Both ports resolve independently. A1=A2 is legal and both ports return identical results.
- BUSY[0] is always 0. BUSY[n] reflects the registered busy bit and is not affected by bypass.

## Timing

- Reset: with rst=1 at a rising edge, all regs ← 0 and all busy bits ← 0. WE3 and IE are ignored on that edge.
- After reset, RD1=RD2=0, RDY1=RDY2=1 and BUSY=0 for any address.
- Assertion of rst in the middle of operation discards all pending scoreboard state. A write-back arriving in the same cycle as rst is lost.
- Write latency:
  - A value written at edge k is readable through regs from the cycle after edge k.
  - With BYPASS=1 it is also visible combinationally during the cycle WE3 is asserted, before edge k.
- Issue latency: busy[AI] and RDY drop become visible after the edge that samples IE. There is no bypass of issue into RDY in the same cycle.
- No back-pressure: every WE3/IE is accepted. The block has no internal state other than regs and busy.

## Test plan

- Reset, then read all 2^ADDR_W addresses on both ports → every RD=0, every RDY=1, BUSY=0.
- Write WE3=1, A3=5, WD3=100, then the next cycle WE3=0, A1=5 → RD1=100, RDY1=1. During the write cycle with A1=5, BYPASS=1 → RD1=100; BYPASS=0 → RD1=0.
- Write WE3=1, A3=0, WD3=0xDEADBEEF, and issue IE=1, AI=0, then read A1=0 → RD1=0, RDY1=1, BUSY[0]=0.
- Issue IE=1, AI=7 → the next cycle BUSY[7]=1 and A2=7 gives RDY2=0. Then WE3=1, A3=7, WD3=42 → same-cycle RDY2=1 with RD2=42 (BYPASS=1). The following cycle BUSY[7]=0 and RD2=42.
- Simultaneous IE=1, AI=9 and WE3=1, A3=9, WD3=3 with busy[9]=1 → after the edge RD of 9 = 3, BUSY[9]=1, RDY=0.
- Load regs 1..4 with 7, 8, 9, 10 and issue AI=2, then assert rst for one cycle → all reads return 0, BUSY=0, RDY1=RDY2=1. A write-back presented during the rst cycle has no effect.

Source files
------------

// File: rtl/register_file_sb.sv
// register_file_sb: integer register file with a per-register busy scoreboard.
// Two combinational read ports, one clocked write-back port, one issue port.
// Register 0 reads as zero, is never stored and is never busy.
module register_file_sb #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_W-1:0]      A1,
    input  logic [ADDR_W-1:0]      A2,
    output logic [XLEN-1:0]        RD1,
    output logic [XLEN-1:0]        RD2,
    output logic                   RDY1,
    output logic                   RDY2,
    input  logic                   WE3,
    input  logic [ADDR_W-1:0]      A3,
    input  logic [XLEN-1:0]        WD3,
    input  logic                   IE,
    input  logic [ADDR_W-1:0]      AI,
    output logic [(1<<ADDR_W)-1:0] BUSY
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [XLEN-1:0]  regs [1:DEPTH-1];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_next;

    logic wb_valid;
    logic issue_valid;

    assign wb_valid    = WE3 && (A3 != '0);
    assign issue_valid = IE && (AI != '0);

    // Next busy vector: retire first, then issue, so a same-address issue wins.
    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first, so no path
        // can leave it unassigned and infer a latch.
        busy_next = busy;
        if (wb_valid) begin
            busy_next[A3] = 1'b0;
        end
        if (issue_valid) begin
            busy_next[AI] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Register storage and scoreboard update; reset clears both and drops any write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the data array is reset on purpose: after reset every register must
            // read as zero, which costs a reset on every storage flop.
            for (int i = 1; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples
            // the pre-edge values of the others.
            if (wb_valid) begin
                regs[A3] <= WD3;
            end
            busy <= busy_next;
        end
    end

    // Resolve one read port: zero register, then write-back bypass, then committed state.
    function automatic logic [XLEN:0] read_port(input logic [ADDR_W-1:0] a);
        logic [XLEN:0] r;
        if (a == '0) begin
            r = {1'b1, {XLEN{1'b0}}};
        end else if ((BYPASS != 0) && WE3 && (A3 == a)) begin
            r = {1'b1, WD3};
        end else begin
            r = {!busy[a], regs[a]};
        end
        return r;
    endfunction

    // Both read ports are purely combinational and resolve independently.
    always_comb begin
        {RDY1, RD1} = read_port(A1);
        {RDY2, RD2} = read_port(A2);
    end

    assign BUSY = busy;

endmodule

// File: tb/tb_register_file_sb.sv
// tb_register_file_sb: directed self-checking bench for register_file_sb.
// One instance with bypass enabled and one without share all inputs.
module tb_register_file_sb;

    localparam int XLEN   = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] A1, A2, A3, AI;
    logic [XLEN-1:0]   WD3;
    logic              WE3, IE;

    logic [XLEN-1:0]   RD1, RD2, RD1_nb, RD2_nb;
    logic              RDY1, RDY2, RDY1_nb, RDY2_nb;
    logic [DEPTH-1:0]  BUSY, BUSY_nb;

    int n_compared = 0;
    int n_mismatched = 0;

    register_file_sb #(.XLEN(XLEN), .ADDR_W(ADDR_W), .BYPASS(1)) dut (
        .clk(clk), .rst(rst),
        .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2), .RDY1(RDY1), .RDY2(RDY2),
        .WE3(WE3), .A3(A3), .WD3(WD3), .IE(IE), .AI(AI), .BUSY(BUSY)
    );

    register_file_sb #(.XLEN(XLEN), .ADDR_W(ADDR_W), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst),
        .A1(A1), .A2(A2), .RD1(RD1_nb), .RD2(RD2_nb), .RDY1(RDY1_nb), .RDY2(RDY2_nb),
        .WE3(WE3), .A3(A3), .WD3(WD3), .IE(IE), .AI(AI), .BUSY(BUSY_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge, then drive/sample away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        WE3 = 1'b0; IE = 1'b0; A3 = '0; AI = '0; WD3 = '0;
    endtask

    initial begin
        rst = 1'b1; A1 = '0; A2 = '0;
        idle();
        tick();
        tick();
        rst = 1'b0;

        // Reset state across every address on both ports.
        for (int a = 0; a < DEPTH; a++) begin
            A1 = ADDR_W'(a);
            A2 = ADDR_W'(DEPTH - 1 - a);
            #1;
            check($sformatf("rst_rd1_%0d", a), RD1, 0);
            check($sformatf("rst_rd2_%0d", a), RD2, 0);
            check($sformatf("rst_rdy1_%0d", a), RDY1, 1);
            check($sformatf("rst_rdy2_%0d", a), RDY2, 1);
        end
        check("rst_busy", BUSY, 0);
        check("rst_busy_nb", BUSY_nb, 0);

        // Write r5 = 100: bypass visible only on the BYPASS=1 instance.
        WE3 = 1'b1; A3 = 5; WD3 = 100; A1 = 5;
        #1;
        check("byp_rd1", RD1, 100);
        check("byp_rdy1", RDY1, 1);
        check("nobyp_rd1", RD1_nb, 0);
        tick();
        idle();
        #1;
        check("wr5_rd1", RD1, 100);
        check("wr5_rdy1", RDY1, 1);
        check("wr5_rd1_nb", RD1_nb, 100);

        // Write and issue to r0 are discarded.
        WE3 = 1'b1; A3 = 0; WD3 = 32'hDEAD_BEEF; IE = 1'b1; AI = 0; A1 = 0;
        tick();
        idle();
        #1;
        check("r0_rd1", RD1, 0);
        check("r0_rdy1", RDY1, 1);
        check("r0_busy", BUSY, 0);

        // Issue r7: no same-cycle effect, busy after the edge.
        IE = 1'b1; AI = 7; A2 = 7;
        #1;
        check("iss7_same_rdy2", RDY2, 1);
        tick();
        idle();
        #1;
        check("iss7_busy", BUSY, 64'h80);
        check("iss7_rdy2", RDY2, 0);
        check("iss7_rdy2_nb", RDY2_nb, 0);
        // Write-back r7 = 42 resolves the hazard combinationally with bypass.
        WE3 = 1'b1; A3 = 7; WD3 = 42;
        #1;
        check("wb7_byp_rdy2", RDY2, 1);
        check("wb7_byp_rd2", RD2, 42);
        check("wb7_nb_rdy2", RDY2_nb, 0);
        check("wb7_nb_rd2", RD2_nb, 0);
        check("wb7_busy_unchanged", BUSY, 64'h80);
        tick();
        idle();
        #1;
        check("wb7_busy", BUSY, 0);
        check("wb7_rd2", RD2, 42);
        check("wb7_rdy2", RDY2, 1);
        check("wb7_rd2_nb", RD2_nb, 42);

        // Same-edge issue and write-back to busy r9: data lands, busy stays set.
        IE = 1'b1; AI = 9;
        tick();
        IE = 1'b1; AI = 9; WE3 = 1'b1; A3 = 9; WD3 = 3;
        tick();
        idle();
        A1 = 9; A2 = 9;
        #1;
        check("same9_rd1", RD1, 3);
        check("same9_rd2", RD2, 3);
        check("same9_busy", BUSY, 64'h200);
        check("same9_rdy1", RDY1, 0);
        check("same9_rdy2", RDY2, 0);

        // Load r1..r4 = 7..10 and issue r2.
        for (int i = 1; i <= 4; i++) begin
            WE3 = 1'b1; A3 = ADDR_W'(i); WD3 = XLEN'(6 + i);
            tick();
        end
        idle();
        IE = 1'b1; AI = 2;
        tick();
        idle();
        for (int i = 1; i <= 4; i++) begin
            A1 = ADDR_W'(i);
            #1;
            check($sformatf("load_rd1_%0d", i), RD1, 64'(6 + i));
        end
        check("load_busy", BUSY, 64'h204);

        // Reset mid-operation with a write-back and an issue in the same cycle.
        rst = 1'b1; WE3 = 1'b1; A3 = 3; WD3 = 55; IE = 1'b1; AI = 4;
        tick();
        rst = 1'b0;
        idle();
        A2 = 9;
        for (int i = 1; i <= 4; i++) begin
            A1 = ADDR_W'(i);
            #1;
            check($sformatf("mrst_rd1_%0d", i), RD1, 0);
            check($sformatf("mrst_rdy1_%0d", i), RDY1, 1);
        end
        check("mrst_rd2", RD2, 0);
        check("mrst_rdy2", RDY2, 1);
        check("mrst_busy", BUSY, 0);
        check("mrst_busy_nb", BUSY_nb, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
